// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, immediate formats, ALU classes and the
// load/store type codes the memory stage also understands.
package decode_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNC   = 2'b10;
  localparam logic [1:0] ALU_MULDIV = 2'b11;

  // Zero means "no memory access" so an idle control word is all zeros.
  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_B    = 3'd1;
  localparam logic [2:0] LD_H    = 3'd2;
  localparam logic [2:0] LD_W    = 3'd3;
  localparam logic [2:0] LD_BU   = 3'd4;
  localparam logic [2:0] LD_HU   = 3'd5;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_B    = 2'd1;
  localparam logic [1:0] ST_H    = 2'd2;
  localparam logic [1:0] ST_W    = 2'd3;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       mem_write;
    logic [2:0] mem_load_type;
    logic [1:0] mem_store_type;
    logic       wb_load;
    logic       wb_reg_file;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  function automatic logic [2:0] load_type(input logic [2:0] f3);
    case (f3)
      3'b000:  return LD_B;
      3'b001:  return LD_H;
      3'b010:  return LD_W;
      3'b100:  return LD_BU;
      3'b101:  return LD_HU;
      default: return LD_NONE;
    endcase
  endfunction

  function automatic logic [1:0] store_type(input logic [2:0] f3);
    case (f3)
      3'b000:  return ST_B;
      3'b001:  return ST_H;
      3'b010:  return ST_W;
      default: return ST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_pipe_imm_gen.sv
// Immediate generator: assembles the I/S/B/U/J immediate and sign-extends it to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instruction,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
      IMM_U: imm32 = {instruction[31:12], 12'b0};
      IMM_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
      default: imm32 = {{20{instruction[31]}}, instruction[31:20]};
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered RV32I decode stage with bypassed register file and load-use stall.
// Define DECODE_M_EXT_EN to decode the M-extension (MUL/DIV) encodings.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       NUM_REGS = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  localparam int unsigned      RA_W     = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic            wb_wr_en,
  input  logic [RA_W-1:0] wb_wr_addr,
  input  logic [XLEN-1:0] wb_wr_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [RA_W-1:0] out_rs1,
  output logic [RA_W-1:0] out_rs2,
  output logic [RA_W-1:0] out_rd,
  output logic [XLEN-1:0] imm,
  output logic [1:0]      alu_op,
  output logic            alu_src,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic            mem_write,
  output logic [2:0]      mem_load_type,
  output logic [1:0]      mem_store_type,
  output logic            wb_load,
  output logic            wb_reg_file,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);

  logic [RA_W-1:0] rs1, rs2, rd;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;

  assign opcode = instruction[6:0];
  assign f3     = instruction[14:12];
  assign f7     = instruction[31:25];
  assign rd     = instruction[7 +: RA_W];
  assign rs1    = instruction[15 +: RA_W];
  assign rs2    = instruction[20 +: RA_W];

  // Register file: entry 0 is never written, and reads of it are forced to zero.
  logic [XLEN-1:0] rf_q [NUM_REGS];
  logic [XLEN-1:0] rs1_val, rs2_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_q <= '{default: '0};
    end else if (wb_wr_en && (wb_wr_addr != '0)) begin
      rf_q[wb_wr_addr] <= wb_wr_data;
    end
  end

  always_comb begin
    rs1_val = rf_q[rs1];
    if (rs1 == '0)                               rs1_val = '0;
    else if (wb_wr_en && (wb_wr_addr == rs1))    rs1_val = wb_wr_data;
    rs2_val = rf_q[rs2];
    if (rs2 == '0)                               rs2_val = '0;
    else if (wb_wr_en && (wb_wr_addr == rs2))    rs2_val = wb_wr_data;
  end

  // Control decode.
  ctrl_t    ctrl;
  imm_fmt_e fmt;
  logic     uses_rs1, uses_rs2, bad;

  always_comb begin
    ctrl       = '0;
    ctrl.func3 = f3;
    ctrl.func7 = f7;
    fmt        = IMM_I;
    uses_rs1   = 1'b1;
    uses_rs2   = 1'b0;
    bad        = 1'b0;
    case (opcode)
      OP: begin
        uses_rs2 = 1'b1;
        if ((f7 == 7'b0000000) ||
            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))) begin
          ctrl.alu_op      = ALU_FUNC;
          ctrl.wb_reg_file = 1'b1;
        end else if (f7 == 7'b0000001) begin
`ifdef DECODE_M_EXT_EN
          ctrl.alu_op      = ALU_MULDIV;
          ctrl.wb_reg_file = 1'b1;
`else
          bad = 1'b1;
`endif
        end else begin
          bad = 1'b1;
        end
      end
      OP_IMM: begin
        ctrl.alu_op      = ALU_FUNC;
        ctrl.alu_src     = 1'b1;
        ctrl.wb_reg_file = 1'b1;
        if ((f3 == 3'b001) && (f7 != 7'b0000000)) bad = 1'b1;
        if ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000)) bad = 1'b1;
      end
      LOAD: begin
        ctrl.alu_src       = 1'b1;
        ctrl.wb_load       = 1'b1;
        ctrl.wb_reg_file   = 1'b1;
        ctrl.mem_load_type = load_type(f3);
        bad                = (ctrl.mem_load_type == LD_NONE);
      end
      STORE: begin
        fmt                 = IMM_S;
        uses_rs2            = 1'b1;
        ctrl.alu_src        = 1'b1;
        ctrl.mem_write      = 1'b1;
        ctrl.mem_store_type = store_type(f3);
        bad                 = (ctrl.mem_store_type == ST_NONE);
      end
      BRANCH: begin
        fmt         = IMM_B;
        uses_rs2    = 1'b1;
        ctrl.alu_op = ALU_BRANCH;
        ctrl.branch = 1'b1;
        bad         = (f3 == 3'b010) || (f3 == 3'b011);
      end
      JAL: begin
        fmt              = IMM_J;
        uses_rs1         = 1'b0;
        ctrl.alu_src     = 1'b1;
        ctrl.jump        = 1'b1;
        ctrl.wb_reg_file = 1'b1;
      end
      JALR: begin
        ctrl.alu_src     = 1'b1;
        ctrl.jump        = 1'b1;
        ctrl.wb_reg_file = 1'b1;
        bad              = (f3 != 3'b000);
      end
      LUI, AUIPC: begin
        fmt              = IMM_U;
        uses_rs1         = 1'b0;
        ctrl.alu_src     = 1'b1;
        ctrl.wb_reg_file = 1'b1;
      end
      SYSTEM: ;
      default: bad = 1'b1;
    endcase
    // An undecodable instruction must have no architectural side effects.
    if (bad) begin
      ctrl         = '0;
      ctrl.func3   = f3;
      ctrl.func7   = f7;
      ctrl.illegal = 1'b1;
    end
  end

  logic [XLEN-1:0] imm_dec;

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instruction (instruction),
    .fmt         (fmt),
    .imm         (imm_dec)
  );

  // ID/EX register and handshake.
  logic            valid_q;
  ctrl_t           ctrl_q;
  logic [XLEN-1:0] pc_q, op1_q, op2_q, imm_q;
  logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
  logic            advance, hz, accept;

  assign advance  = ex_ready | ~valid_q;
  assign hz       = in_valid & valid_q & ctrl_q.wb_load & (rd_q != '0) &
                    ((uses_rs1 & (rs1 == rd_q)) | (uses_rs2 & (rs2 == rd_q)));
  assign in_ready = flush | (advance & ~hz);
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= RESET_PC;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (advance) begin
      valid_q <= accept;
      if (accept) begin
        ctrl_q <= ctrl;
        pc_q   <= pc;
        op1_q  <= rs1_val;
        op2_q  <= rs2_val;
        imm_q  <= imm_dec;
        rs1_q  <= rs1;
        rs2_q  <= rs2;
        rd_q   <= rd;
      end
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign op1            = op1_q;
  assign op2            = op2_q;
  assign out_rs1        = rs1_q;
  assign out_rs2        = rs2_q;
  assign out_rd         = rd_q;
  assign imm            = imm_q;
  assign alu_op         = ctrl_q.alu_op;
  assign alu_src        = ctrl_q.alu_src;
  assign func3          = ctrl_q.func3;
  assign func7          = ctrl_q.func7;
  assign mem_write      = ctrl_q.mem_write;
  assign mem_load_type  = ctrl_q.mem_load_type;
  assign mem_store_type = ctrl_q.mem_store_type;
  assign wb_load        = ctrl_q.wb_load;
  assign wb_reg_file    = ctrl_q.wb_reg_file;
  assign branch         = ctrl_q.branch;
  assign jump           = ctrl_q.jump;
  assign illegal        = ctrl_q.illegal;

endmodule
